// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ producers.
// Grants a bounded burst per owner, honours fifo_full, and inserts one idle cycle between grants.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      wclk,
  input  logic                      wrst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  output logic [WIDTH-1:0]          fifo_wdata,
  output logic                      fifo_wen,
  input  logic                      fifo_full,
  output logic [NREQ-1:0]           grant,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [BW-1:0]   beat_cnt;

  logic            found;
  logic [IW-1:0]   pick;
  logic [IW:0]     sum;
  logic [IW-1:0]   cand;
  logic            own_valid;
  logic            own_last;
  logic [WIDTH-1:0] own_data;
  logic            xfer;
  logic            release_now;
  logic [IW-1:0]   next_ptr;

  // first valid requester searching upward from rr_ptr with wrap-around
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NREQ))
        sum = sum - (IW+1)'(NREQ);
      cand = sum[IW-1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // grant is zero outside BURST, so the owner mux naturally yields zeros when idle
  always_comb begin
    own_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i])
        own_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign own_valid   = |(req_valid & grant);
  assign own_last    = |(req_last & grant);
  assign xfer        = (state == BURST) && own_valid && !fifo_full;
  assign release_now = !own_valid ||
                       (xfer && (own_last || beat_cnt == BW'(MAX_BURST - 1)));
  assign next_ptr    = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  assign req_ready  = fifo_full ? '0 : grant;
  assign fifo_wen   = xfer;
  assign fifo_wdata = own_data;
  assign busy       = (state == BURST);

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state    <= BURST;
            grant    <= NREQ'(1) << pick;
            grant_id <= pick;
            beat_cnt <= '0;
          end
        end
        BURST: begin
          // a full stall keeps own_valid high with no transfer, so the grant holds
          if (release_now) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= next_ptr;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: an integer-level arbitration model predicts writes
// and grants; a separate monitor compares DUT outputs against those predictions.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  localparam int MAX_BURST = 4;
  localparam int IW = $clog2(NREQ);

  logic                    wclk = 1'b0;
  logic                    wrst = 1'b1;
  logic [NREQ-1:0]         req_valid = '0;
  logic [NREQ*WIDTH-1:0]   req_data = '0;
  logic [NREQ-1:0]         req_last = '0;
  logic [NREQ-1:0]         req_ready;
  logic [WIDTH-1:0]        fifo_wdata;
  logic                    fifo_wen;
  logic                    fifo_full = 1'b0;
  logic [NREQ-1:0]         grant;
  logic [IW-1:0]           grant_id;
  logic                    busy;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_wdata(fifo_wdata),
    .fifo_wen(fifo_wen), .fifo_full(fifo_full), .grant(grant),
    .grant_id(grant_id), .busy(busy)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    int               id;
  } wr_t;
  wr_t wq[$];

  int errors = 0;
  int checks = 0;

  // reference model state: owner = -1 when nobody holds the port
  int owner = -1;
  int rr = 0;
  int beats = 0;
  int last_id = 0;

  logic [NREQ-1:0] exp_grant = '0;
  logic [NREQ-1:0] exp_ready = '0;
  logic            exp_wen = 1'b0;
  logic            exp_busy = 1'b0;
  int              exp_id = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_eval();
    int g;
    int k;
    if (wrst) begin
      owner = -1; rr = 0; beats = 0; last_id = 0;
      exp_grant = '0; exp_ready = '0; exp_wen = 1'b0; exp_busy = 1'b0; exp_id = 0;
      return;
    end
    exp_id = last_id;
    if (owner < 0) begin
      exp_grant = '0; exp_ready = '0; exp_wen = 1'b0; exp_busy = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        k = (rr + i) % NREQ;
        if (req_valid[IW'(k)]) begin
          owner = k; last_id = k; beats = 0;
          break;
        end
      end
    end else begin
      g = owner;
      exp_grant = NREQ'(1 << g);
      exp_busy  = 1'b1;
      exp_ready = fifo_full ? '0 : exp_grant;
      exp_wen   = req_valid[IW'(g)] && !fifo_full;
      if (exp_wen)
        wq.push_back('{req_data[g*WIDTH +: WIDTH], g});
      if (!req_valid[IW'(g)]) begin
        owner = -1; rr = (g + 1) % NREQ;
      end else if (exp_wen) begin
        beats++;
        if (req_last[IW'(g)] || beats == MAX_BURST) begin
          owner = -1; rr = (g + 1) % NREQ;
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic [NREQ-1:0] v, input logic [NREQ-1:0] l,
                      input logic f, input logic [NREQ*WIDTH-1:0] d);
    @(negedge wclk);
    wrst = rst; req_valid = v; req_last = l; fifo_full = f; req_data = d;
    #1;
    model_eval();
  endtask

  function automatic logic [NREQ*WIDTH-1:0] slot(input int p, input logic [WIDTH-1:0] b);
    logic [NREQ*WIDTH-1:0] r;
    r = '0;
    r[p*WIDTH +: WIDTH] = b;
    return r;
  endfunction

  // monitor: per-cycle control comparison, plus scoreboard pop on every write
  initial begin
    wr_t e;
    forever begin
      @(negedge wclk);
      #2;
      check("grant", 32'(grant), 32'(exp_grant));
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("fifo_wen", 32'(fifo_wen), 32'(exp_wen));
      check("busy", 32'(busy), 32'(exp_busy));
      check("grant_id", 32'(grant_id), 32'(exp_id));
      if (exp_grant == '0)
        check("wdata_idle", 32'(fifo_wdata), 32'(0));
      if (fifo_wen) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got data %0h id %0d expected no write", fifo_wdata, grant_id);
        end else begin
          e = wq.pop_front();
          check("wdata", 32'(fifo_wdata), 32'(e.data));
          check("write_id", 32'(grant_id), 32'(e.id));
        end
      end
    end
  end

  initial begin
    logic [NREQ-1:0]       rv, rl;
    logic                  rf;
    logic [NREQ*WIDTH-1:0] rd;

    // reset, then idle with no requests
    repeat (3) step(1'b1, '0, '0, 1'b0, '0);
    repeat (5) step(1'b0, '0, '0, 1'b0, '0);

    // producer 2: A0, A1, A2 (last on A2)
    step(1'b0, 4'b0100, 4'b0000, 1'b0, slot(2, 8'hA0));
    step(1'b0, 4'b0100, 4'b0000, 1'b0, slot(2, 8'hA0));
    step(1'b0, 4'b0100, 4'b0000, 1'b0, slot(2, 8'hA1));
    step(1'b0, 4'b0100, 4'b0100, 1'b0, slot(2, 8'hA2));
    step(1'b0, 4'b0000, 4'b0000, 1'b0, '0);
    // producers 0 and 3: search from 3 picks 3 first
    repeat (3) step(1'b0, 4'b1001, 4'b1001, 1'b0, slot(0, 8'h05) | slot(3, 8'h35));
    repeat (3) step(1'b0, 4'b0000, 4'b0000, 1'b0, '0);

    // all continuously valid, no last
    for (int c = 0; c < 30; c++)
      step(1'b0, 4'b1111, 4'b0000, 1'b0,
           slot(0, 8'(c)) | slot(1, 8'(c + 64)) | slot(2, 8'(c + 128)) | slot(3, 8'(c + 192)));
    repeat (2) step(1'b0, '0, '0, 1'b0, '0);

    // producer 1 stalled by full after 2 words
    step(1'b0, 4'b0010, 4'b0000, 1'b0, slot(1, 8'h10));
    step(1'b0, 4'b0010, 4'b0000, 1'b0, slot(1, 8'h10));
    step(1'b0, 4'b0010, 4'b0000, 1'b0, slot(1, 8'h11));
    repeat (5) step(1'b0, 4'b0010, 4'b0000, 1'b1, slot(1, 8'h12));
    step(1'b0, 4'b0010, 4'b0000, 1'b0, slot(1, 8'h12));
    step(1'b0, 4'b0010, 4'b0000, 1'b0, slot(1, 8'h13));
    repeat (2) step(1'b0, '0, '0, 1'b0, '0);

    // producer 0 drops valid after one word while producer 3 waits
    step(1'b0, 4'b0001, 4'b0000, 1'b0, slot(0, 8'h01));
    step(1'b0, 4'b1001, 4'b0000, 1'b0, slot(0, 8'h01) | slot(3, 8'h31));
    step(1'b0, 4'b1000, 4'b0000, 1'b0, slot(3, 8'h31));
    repeat (3) step(1'b0, 4'b1000, 4'b1000, 1'b0, slot(3, 8'h32));
    repeat (2) step(1'b0, '0, '0, 1'b0, '0);

    // reset during a burst of producer 2, then 2 and 0 valid
    repeat (3) step(1'b0, 4'b0100, 4'b0000, 1'b0, slot(2, 8'h2A));
    repeat (2) step(1'b1, 4'b0100, 4'b0000, 1'b0, slot(2, 8'h2B));
    repeat (6) step(1'b0, 4'b0101, 4'b0000, 1'b0, slot(2, 8'h2C) | slot(0, 8'h0C));
    repeat (2) step(1'b0, '0, '0, 1'b0, '0);

    // randomized traffic with occasional full and reset
    for (int c = 0; c < 3000; c++) begin
      rv = '0; rl = '0;
      for (int p = 0; p < NREQ; p++) begin
        rv[p] = ($urandom_range(0, 3) != 0);
        rl[p] = ($urandom_range(0, 3) == 0);
      end
      rf = ($urandom_range(0, 5) == 0);
      rd = '0;
      for (int p = 0; p < NREQ; p++)
        rd[p*WIDTH +: WIDTH] = 8'($urandom);
      step(($urandom_range(0, 299) == 0), rv, rl, rf, rd);
    end
    repeat (4) step(1'b0, '0, '0, 1'b0, '0);

    @(negedge wclk);
    #3;
    check("scoreboard_drained", 32'(wq.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
